// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
//   Shares one byte-level SPI engine between NUM_REQ requesters. Requests are
//   granted round-robin. Each transaction is framed as a command byte
//   (0x0A write / 0x0B read), an address byte, then 1..MAX_LEN data bytes,
//   all inside one cs_n low window. Read data is returned to the granted
//   requester with a one-cycle rsp_valid pulse.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester request / one-hot accept pulse
//   req_rw/addr/len/wdata    per-requester transaction fields (sliced by index)
//   eng_tx_valid/ready/byte  byte offered to the SPI engine (valid/ready)
//   eng_rx_valid/byte        received byte for the last accepted tx byte
//   cs_n                     chip select, active low
//   rsp_valid/id/rdata       completion pulse, requester index, read bytes
module spi_txn_scheduler #(
    parameter int NUM_REQ      = 2,
    parameter int MAX_LEN      = 4,
    parameter int CS_SETUP_CYC = 1,
    parameter int CS_GAP_CYC   = 2,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [8*NUM_REQ-1:0]         req_addr,
    input  logic [4*NUM_REQ-1:0]         req_len,
    input  logic [8*MAX_LEN*NUM_REQ-1:0] req_wdata,
    output logic                         eng_tx_valid,
    input  logic                         eng_tx_ready,
    output logic [7:0]                   eng_tx_byte,
    input  logic                         eng_rx_valid,
    input  logic [7:0]                   eng_rx_byte,
    output logic                         cs_n,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [8*MAX_LEN-1:0]         rsp_rdata
);
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_MAX = (CS_SETUP_CYC > CS_GAP_CYC) ? CS_SETUP_CYC : CS_GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_GAP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_rx_q, wait_rx_d;   // one byte outstanding at the engine
    logic [IDX_W-1:0] idx_q, idx_d;           // current data byte
    logic [IDX_W-1:0] last_q, last_d;         // index of final data byte (clamped)
    logic             rw_q, rw_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q [MAX_LEN];
    logic [7:0]       wdata_d [MAX_LEN];
    logic [7:0]       rdata_q [MAX_LEN];
    logic [7:0]       rdata_d [MAX_LEN];
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic             rsp_valid_q, rsp_valid_d;

    // Unpacked per-requester views of the flat request buses.
    logic [7:0] addr_a  [NUM_REQ];
    logic [3:0] len_a   [NUM_REQ];
    logic [7:0] wbyte_a [NUM_REQ][MAX_LEN];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_a[gi] = req_addr[8*gi +: 8];
            assign len_a[gi]  = req_len[4*gi +: 4];
            for (genvar gj = 0; gj < MAX_LEN; gj++) begin : g_byte
                assign wbyte_a[gi][gj] = req_wdata[8*(gi*MAX_LEN+gj) +: 8];
            end
        end
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_rsp
            assign rsp_rdata[8*gi +: 8] = rdata_q[gi];
        end
    endgenerate

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;

    // Round-robin pick: first valid index at or after rr_q, wrapping.
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        cand      = rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wait_rx_q   <= 1'b0;
            idx_q       <= '0;
            last_q      <= '0;
            rw_q        <= 1'b0;
            addr_q      <= 8'h00;
            id_q        <= '0;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            for (int j = 0; j < MAX_LEN; j++) begin
                wdata_q[j] <= 8'h00;
                rdata_q[j] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_rx_q   <= wait_rx_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            for (int j = 0; j < MAX_LEN; j++) begin
                wdata_q[j] <= wdata_d[j];
                rdata_q[j] <= rdata_d[j];
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_rx_d   = wait_rx_q;
        idx_d       = idx_q;
        last_d      = last_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        id_d        = id_q;
        rr_d        = rr_q;
        rsp_valid_d = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
            wdata_d[j] = wdata_q[j];
            rdata_d[j] = rdata_q[j];
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    id_d    = gnt_idx;
                    rw_d    = req_rw[gnt_idx];
                    addr_d  = addr_a[gnt_idx];
                    for (int j = 0; j < MAX_LEN; j++) begin
                        wdata_d[j] = wbyte_a[gnt_idx][j];
                        rdata_d[j] = 8'h00;
                    end
                    // len 0 behaves as 1; anything above MAX_LEN is clamped
                    if (len_a[gnt_idx] == 4'd0)
                        last_d = '0;
                    else if (int'(len_a[gnt_idx]) > MAX_LEN)
                        last_d = IDX_W'(MAX_LEN - 1);
                    else
                        last_d = IDX_W'(int'(len_a[gnt_idx]) - 1);
                    rr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    state_d   = S_CMD;
                    wait_rx_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (!wait_rx_q) begin
                    if (eng_tx_ready) wait_rx_d = 1'b1;
                end else if (eng_rx_valid) begin
                    wait_rx_d = 1'b0;
                    case (state_q)
                        S_CMD:  state_d = S_ADDR;
                        S_ADDR: begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end
                        default: begin
                            if (rw_q) rdata_d[idx_q] = eng_rx_byte;
                            if (idx_q == last_q) begin
                                state_d     = S_GAP;
                                cnt_d       = '0;
                                rsp_valid_d = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_GAP: begin
                // The rsp_valid cycle is the first gap cycle.
                if (cnt_q == CNT_W'(CS_GAP_CYC - 1))
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cs_n         = 1'b1;
        eng_tx_valid = 1'b0;
        eng_tx_byte  = 8'h00;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                // gated by rst so no accept pulse can appear while held in reset
                if (gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
            end
            S_SETUP: cs_n = 1'b0;
            S_CMD: begin
                cs_n         = 1'b0;
                eng_tx_valid = !wait_rx_q;
                eng_tx_byte  = rw_q ? 8'h0B : 8'h0A;
            end
            S_ADDR: begin
                cs_n         = 1'b0;
                eng_tx_valid = !wait_rx_q;
                eng_tx_byte  = addr_q;
            end
            S_DATA: begin
                cs_n         = 1'b0;
                eng_tx_valid = !wait_rx_q;
                eng_tx_byte  = rw_q ? 8'h00 : wdata_q[idx_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed testbench for spi_txn_scheduler (NUM_REQ=2, MAX_LEN=4,
// CS_SETUP_CYC=1, CS_GAP_CYC=2). A small engine model answers every
// accepted tx byte with an rx byte two cycles later and logs traffic.
module tb_spi_txn_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_rw;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [63:0] req_wdata;
    logic        eng_tx_valid, eng_tx_ready, eng_rx_valid;
    logic [7:0]  eng_tx_byte, eng_rx_byte;
    logic        cs_n, rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    spi_txn_scheduler #(
        .NUM_REQ(2), .MAX_LEN(4), .CS_SETUP_CYC(1), .CS_GAP_CYC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .eng_tx_valid(eng_tx_valid), .eng_tx_ready(eng_tx_ready), .eng_tx_byte(eng_tx_byte),
        .eng_rx_valid(eng_rx_valid), .eng_rx_byte(eng_rx_byte),
        .cs_n(cs_n), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // engine model / monitor state
    logic [7:0] tx_log[$];
    logic [7:0] rx_q[$];
    int         grant_log[$];
    int         rx_cnt = 0;
    int         stall_left = 0;
    int         stall_cycles = 0;
    int         unstable = 0;
    logic [7:0] stall_byte = 8'h00;
    int         rsp_cnt = 0;
    int         last_id = -1;
    logic [31:0] last_rdata = 32'hDEAD_BEEF;
    int         cs_viol = 0;
    int         hi_run = 0;
    int         seen_low = 0;
    int         min_gap = 1000;

    initial begin
        eng_tx_ready = 1'b1;
        eng_rx_valid = 1'b0;
        eng_rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            eng_rx_valid = 1'b0;
            if (rst) begin
                rx_cnt = 0;
                rx_q.delete();
                eng_tx_ready = 1'b1;
            end else begin
                if (rx_cnt > 0) begin
                    rx_cnt--;
                    if (rx_cnt == 0) begin
                        eng_rx_valid = 1'b1;
                        if (rx_q.size() > 0) eng_rx_byte = rx_q.pop_front();
                        else eng_rx_byte = 8'h00;
                    end
                end
                if (stall_left > 0 && eng_tx_valid) begin
                    if (stall_cycles == 0) stall_byte = eng_tx_byte;
                    else if (eng_tx_byte !== stall_byte) unstable++;
                    stall_cycles++;
                    stall_left--;
                    eng_tx_ready = 1'b0;
                end else begin
                    eng_tx_ready = 1'b1;
                end
                if (eng_tx_valid && eng_tx_ready) begin
                    tx_log.push_back(eng_tx_byte);
                    rx_cnt = 2;
                    if (cs_n !== 1'b0) cs_viol++;
                end
                if (req_ready != 2'b00) grant_log.push_back(req_ready[1] ? 1 : 0);
                if (rsp_valid) begin
                    rsp_cnt++;
                    last_id    = int'(rsp_id);
                    last_rdata = rsp_rdata;
                    if (cs_n !== 1'b1) cs_viol++;
                end
            end
            if (cs_n) begin
                hi_run++;
            end else begin
                if (seen_low != 0 && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                seen_low = 1;
                hi_run   = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // exp lists bytes in send order, first byte most significant
    task automatic chk_log(input string tag, input int n, input logic [127:0] exp);
        logic [7:0] e;
        logic [7:0] o;
        chk($sformatf("%s_count", tag), 64'(tx_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            e = exp[8*(n-1-i) +: 8];
            o = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), 64'(o), 64'(e));
        end
    endtask

    task automatic wait_grant(input int target, input string tag);
        int c;
        c = 0;
        while (grant_log.size() < target && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(grant_log.size() >= target), 64'(1));
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int c;
        c = 0;
        while (rsp_cnt < target && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(rsp_cnt >= target), 64'(1));
    endtask

    task automatic show(input string name);
        $display("txn %s: rsp_id=%0d rdata=0x%08h tx_bytes=%0d rsp_count=%0d",
                 name, last_id, last_rdata, tx_log.size(), rsp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_rw = 2'b00; req_addr = '0; req_len = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(cs_n), 64'(1));
        chk("rst_tx_valid", 64'(eng_tx_valid), 64'(0));
        chk("rst_tx_byte", 64'(eng_tx_byte), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: write req0 addr 0x2D len 1 data 0x02
        tx_log.delete();
        req_rw = 2'b00; req_addr[7:0] = 8'h2D; req_len[3:0] = 4'd1; req_wdata[31:0] = 32'h0000_0002;
        req_valid = 2'b01;
        wait_grant(1, "t1_grant");
        req_valid = 2'b00;
        wait_rsp(1, "t1_rsp");
        repeat (5) @(negedge clk);
        chk_log("t1_tx", 3, {8'h0A, 8'h2D, 8'h02});
        chk("t1_grant_id", 64'(grant_log[0]), 64'(0));
        chk("t1_rsp_count", 64'(rsp_cnt), 64'(1));
        chk("t1_rsp_id", 64'(last_id), 64'(0));
        chk("t1_rdata", 64'(last_rdata), 64'(0));
        show("t1_write");

        // 2: read req1 addr 0x08 len 2
        tx_log.delete();
        rx_q.push_back(8'hFF); rx_q.push_back(8'hFF); rx_q.push_back(8'h12); rx_q.push_back(8'h34);
        req_rw = 2'b10; req_addr[15:8] = 8'h08; req_len[7:4] = 4'd2;
        req_valid = 2'b10;
        wait_grant(2, "t2_grant");
        req_valid = 2'b00;
        wait_rsp(2, "t2_rsp");
        repeat (5) @(negedge clk);
        chk_log("t2_tx", 4, {8'h0B, 8'h08, 8'h00, 8'h00});
        chk("t2_grant_id", 64'(grant_log[1]), 64'(1));
        chk("t2_rsp_id", 64'(last_id), 64'(1));
        chk("t2_rdata", 64'(last_rdata), 64'h0000_3412);
        chk("t2_rdata_hold", 64'(rsp_rdata), 64'h0000_3412);
        show("t2_read");

        // 3: both requesters valid continuously -> 0,1,0,1
        tx_log.delete(); grant_log.delete();
        min_gap = 1000; seen_low = 0; hi_run = 0;
        req_rw = 2'b00; req_addr = {8'h20, 8'h10}; req_len = {4'd1, 4'd1};
        req_wdata = {32'h0000_005A, 32'h0000_00A5};
        req_valid = 2'b11;
        wait_rsp(6, "t3_rsp");
        req_valid = 2'b00;
        repeat (6) @(negedge clk);
        chk("t3_grants", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
        chk("t3_min_gap", 64'(min_gap), 64'(3));
        chk_log("t3_tx", 12, {8'h0A, 8'h10, 8'hA5, 8'h0A, 8'h20, 8'h5A,
                              8'h0A, 8'h10, 8'hA5, 8'h0A, 8'h20, 8'h5A});
        chk("t3_rsp_id", 64'(last_id), 64'(1));
        chk("t3_cs_viol", 64'(cs_viol), 64'(0));
        show("t3_alternate");

        // 4: engine stalls the first byte for 10 cycles
        tx_log.delete();
        stall_left = 10;
        req_rw = 2'b00; req_addr[7:0] = 8'h44; req_len[3:0] = 4'd2; req_wdata[31:0] = 32'h0000_2211;
        req_valid = 2'b01;
        wait_grant(5, "t4_grant");
        req_valid = 2'b00;
        wait_rsp(7, "t4_rsp");
        repeat (5) @(negedge clk);
        chk("t4_stall_cycles", 64'(stall_cycles), 64'(10));
        chk("t4_unstable", 64'(unstable), 64'(0));
        chk_log("t4_tx", 4, {8'h0A, 8'h44, 8'h11, 8'h22});
        chk("t4_rsp_id", 64'(last_id), 64'(0));
        show("t4_stall");

        // 5a: read req1 with len 0 -> one data byte
        tx_log.delete();
        rx_q.push_back(8'hAA); rx_q.push_back(8'hBB); rx_q.push_back(8'hCC);
        req_rw = 2'b10; req_addr[15:8] = 8'h33; req_len[7:4] = 4'd0;
        req_valid = 2'b10;
        wait_grant(6, "t5a_grant");
        req_valid = 2'b00;
        wait_rsp(8, "t5a_rsp");
        repeat (5) @(negedge clk);
        chk_log("t5a_tx", 3, {8'h0B, 8'h33, 8'h00});
        chk("t5a_rsp_id", 64'(last_id), 64'(1));
        chk("t5a_rdata", 64'(last_rdata), 64'h0000_00CC);
        show("t5a_len0");

        // 5b: write req0 with len 9 -> clamped to 4 data bytes
        tx_log.delete();
        req_rw = 2'b00; req_addr[7:0] = 8'h55; req_len[3:0] = 4'd9; req_wdata[31:0] = 32'h0403_0201;
        req_valid = 2'b01;
        wait_grant(7, "t5b_grant");
        req_valid = 2'b00;
        wait_rsp(9, "t5b_rsp");
        repeat (5) @(negedge clk);
        chk_log("t5b_tx", 6, {8'h0A, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04});
        chk("t5b_rsp_id", 64'(last_id), 64'(0));
        chk("t5b_rdata", 64'(last_rdata), 64'h0);
        show("t5b_len9");

        // 6: reset in the middle of DATA
        tx_log.delete();
        req_rw = 2'b00; req_addr[7:0] = 8'h66; req_len[3:0] = 4'd4; req_wdata[31:0] = 32'h0403_0201;
        req_valid = 2'b01;
        wait_grant(8, "t6_grant");
        req_valid = 2'b00;
        begin
            int c;
            c = 0;
            while (tx_log.size() < 3 && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("t6_reach_data", 64'(tx_log.size() >= 3), 64'(1));
        end
        #2;
        chk("t6_pre_cs_n", 64'(cs_n), 64'(0));
        rst = 1'b1;
        #1;
        chk("t6_rst_cs_n", 64'(cs_n), 64'(1));
        chk("t6_rst_tx_valid", 64'(eng_tx_valid), 64'(0));
        chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_no_rsp", 64'(rsp_cnt), 64'(9));
        chk("t6_idle_cs_n", 64'(cs_n), 64'(1));
        $display("txn t6_reset: dropped after %0d tx bytes, rsp_count=%0d", tx_log.size(), rsp_cnt);

        // after reset the RR pointer is back at 0: req0 wins over req1
        tx_log.delete(); grant_log.delete();
        rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h9C);
        req_rw = 2'b11; req_addr = {8'h88, 8'h77}; req_len = {4'd1, 4'd1};
        req_valid = 2'b11;
        wait_grant(1, "t6b_grant");
        req_valid = 2'b00;
        chk("t6b_grant_id", 64'(grant_log[0]), 64'(0));
        wait_rsp(10, "t6b_rsp");
        repeat (5) @(negedge clk);
        chk_log("t6b_tx", 3, {8'h0B, 8'h77, 8'h00});
        chk("t6b_rsp_id", 64'(last_id), 64'(0));
        chk("t6b_rdata", 64'(last_rdata), 64'h0000_009C);
        chk("t6b_rsp_count", 64'(rsp_cnt), 64'(10));
        show("t6b_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
